// File: rtl/prog_loader.sv
// prog_loader: 16x8 instruction memory for the 4-bit CPU plus the loader that
// fills it from a valid/ready byte stream (16 program bytes + 1 checksum byte)
// and releases the CPU only once the loaded program has been verified.
//
// Ports:
//   clk_cpu     in   1  CPU clock, rising edge
//   reset       in   1  asynchronous active-low reset
//   pc          in   4  CPU fetch address
//   inst        out  8  mem[pc], combinational read
//   load_start  in   1  pulse: begin (or restart) a program load
//   wr_data     in   8  program / checksum byte
//   wr_valid    in   1  wr_data valid
//   wr_ready    out  1  loader accepts a byte this cycle (registered)
//   cpu_run     out  1  program loaded and verified (registered)
//   load_err    out  1  last load failed its checksum (registered)
module prog_loader (
   input  logic       clk_cpu,
   input  logic       reset,
   input  logic [3:0] pc,
   output logic [7:0] inst,
   input  logic       load_start,
   input  logic [7:0] wr_data,
   input  logic       wr_valid,
   output logic       wr_ready,
   output logic       cpu_run,
   output logic       load_err
);

   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CHECK = 3'd2,
      S_RUN   = 3'd3,
      S_ERR   = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
   logic [DW-1:0]   sum_q, sum_d;
   logic            load_err_q, load_err_d;
   logic            wr_ready_q, cpu_run_q;
   logic            we_c;
   logic            xfer_c;
   logic [DW-1:0]   mem_q [DEPTH];

   // wr_ready_q is high exactly in LOAD/CHECK, so it also qualifies transfers
   assign xfer_c = wr_valid && wr_ready_q;

   // Next-state, counter/checksum and write-enable logic
   always_comb begin
      state_d    = state_q;
      wr_cnt_d   = wr_cnt_q;
      sum_d      = sum_q;
      load_err_d = load_err_q;
      we_c       = 1'b0;

      if (load_start) begin
         // A byte arriving alongside load_start is dropped on purpose
         state_d    = S_LOAD;
         wr_cnt_d   = '0;
         sum_d      = '0;
         load_err_d = 1'b0;
      end else begin
         unique case (state_q)
            S_LOAD: begin
               if (xfer_c) begin
                  we_c     = 1'b1;
                  sum_d    = sum_q + wr_data;
                  wr_cnt_d = wr_cnt_q + AW'(1);
                  if (wr_cnt_q == AW'(DEPTH - 1)) state_d = S_CHECK;
               end
            end
            S_CHECK: begin
               if (xfer_c) begin
                  if (wr_data == sum_q) begin
                     state_d = S_RUN;
                  end else begin
                     state_d    = S_ERR;
                     load_err_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Control state and registered output decodes of the next state
   always_ff @(posedge clk_cpu or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         wr_cnt_q   <= '0;
         sum_q      <= '0;
         load_err_q <= 1'b0;
         wr_ready_q <= 1'b0;
         cpu_run_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_cnt_q   <= wr_cnt_d;
         sum_q      <= sum_d;
         load_err_q <= load_err_d;
         wr_ready_q <= (state_d == S_LOAD) || (state_d == S_CHECK);
         cpu_run_q  <= (state_d == S_RUN);
      end
   end

   // Program memory, cleared by reset so the CPU never fetches stale code
   always_ff @(posedge clk_cpu or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (we_c) begin
         mem_q[wr_cnt_q] <= wr_data;
      end
   end

   assign inst     = mem_q[pc];
   assign wr_ready = wr_ready_q;
   assign cpu_run  = cpu_run_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader.
module tb_prog_loader;

   logic       clk_cpu;
   logic       reset;
   logic [3:0] pc;
   logic [7:0] inst;
   logic       load_start;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       wr_ready;
   logic       cpu_run;
   logic       load_err;

   int n_cmp;
   int n_err;

   prog_loader dut (
      .clk_cpu    (clk_cpu),
      .reset      (reset),
      .pc         (pc),
      .inst       (inst),
      .load_start (load_start),
      .wr_data    (wr_data),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .cpu_run    (cpu_run),
      .load_err   (load_err)
   );

   initial begin
      clk_cpu = 1'b0;
      forever #5 clk_cpu = ~clk_cpu;
   end

   // Advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk_cpu);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic read_mem(input logic [3:0] a, input logic [7:0] exp, input string tag);
      pc = a;
      #1;
      check(tag, inst, exp);
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   // Present one byte and hold it until accepted, bounded by a cycle budget
   task automatic send_byte(input logic [7:0] b);
      bit done;
      done = 1'b0;
      wr_valid = 1'b1;
      wr_data  = b;
      for (int c = 0; c < 20 && !done; c++) begin
         if (wr_ready) done = 1'b1;
         tick();
      end
      wr_valid = 1'b0;
      if (!done) check("send_byte_timeout", 8'h00, 8'h01);
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      reset      = 1'b0;
      pc         = 4'd0;
      load_start = 1'b0;
      wr_data    = 8'h00;
      wr_valid   = 1'b0;

      // Reset state
      #12;
      check("rst_wr_ready", {7'd0, wr_ready}, 8'h00);
      check("rst_cpu_run",  {7'd0, cpu_run},  8'h00);
      check("rst_load_err", {7'd0, load_err}, 8'h00);
      check("rst_inst",     inst,             8'h00);
      reset = 1'b1;
      tick();

      // Reset mid-load after 5 bytes
      pulse_start();
      check("load_wr_ready", {7'd0, wr_ready}, 8'h01);
      for (int i = 0; i < 5; i++) send_byte(8'hA1 + 8'(i));
      read_mem(4'd2, 8'hA3, "partial_mem2");
      #2;
      reset = 1'b0;
      #1;
      check("midrst_wr_ready", {7'd0, wr_ready}, 8'h00);
      check("midrst_cpu_run",  {7'd0, cpu_run},  8'h00);
      check("midrst_load_err", {7'd0, load_err}, 8'h00);
      for (int a = 0; a < 16; a++) read_mem(4'(a), 8'h00, "midrst_inst");
      #1;
      reset = 1'b1;
      // Stream bytes without load_start: must be ignored
      wr_valid = 1'b1;
      wr_data  = 8'h5A;
      tick(); tick(); tick();
      wr_valid = 1'b0;
      check("idle_wr_ready", {7'd0, wr_ready}, 8'h00);
      read_mem(4'd0, 8'h00, "idle_no_write");

      // Back-to-back load 0x00..0x0F, checksum 0x78
      pulse_start();
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      check("check_wr_ready", {7'd0, wr_ready}, 8'h01);
      check("check_cpu_run",  {7'd0, cpu_run},  8'h00);
      send_byte(8'h78);
      check("b2b_cpu_run",  {7'd0, cpu_run},  8'h01);
      check("b2b_load_err", {7'd0, load_err}, 8'h00);
      check("b2b_wr_ready", {7'd0, wr_ready}, 8'h00);
      read_mem(4'd7,  8'h07, "b2b_mem7");
      read_mem(4'd15, 8'h0F, "b2b_mem15");
      // Bytes offered in RUN are ignored
      wr_valid = 1'b1;
      wr_data  = 8'hEE;
      tick(); tick();
      wr_valid = 1'b0;
      read_mem(4'd0, 8'h00, "run_no_write");
      check("run_hold", {7'd0, cpu_run}, 8'h01);

      // Reload from RUN
      pulse_start();
      check("reload_cpu_run",  {7'd0, cpu_run},  8'h00);
      check("reload_wr_ready", {7'd0, wr_ready}, 8'h01);
      read_mem(4'd7, 8'h07, "reload_old_prog");
      send_byte(8'h55);
      read_mem(4'd0, 8'h55, "reload_new_mem0");
      read_mem(4'd1, 8'h01, "reload_old_mem1");

      // Bad checksum
      pulse_start();
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      send_byte(8'h77);
      check("bad_load_err", {7'd0, load_err}, 8'h01);
      check("bad_cpu_run",  {7'd0, cpu_run},  8'h00);
      check("bad_wr_ready", {7'd0, wr_ready}, 8'h00);
      pulse_start();
      check("bad_clear_err", {7'd0, load_err}, 8'h00);
      check("bad_restart_rdy", {7'd0, wr_ready}, 8'h01);

      // Restart with a byte at wr_cnt = 9 alongside load_start
      for (int i = 0; i < 9; i++) send_byte(8'h30 + 8'(i));
      load_start = 1'b1;
      wr_valid   = 1'b1;
      wr_data    = 8'hCC;
      tick();
      load_start = 1'b0;
      wr_valid   = 1'b0;
      read_mem(4'd9, 8'h09, "restart_dropped");
      check("restart_wr_ready", {7'd0, wr_ready}, 8'h01);
      send_byte(8'hD0);
      read_mem(4'd0, 8'hD0, "restart_addr0");
      read_mem(4'd9, 8'h09, "restart_mem9");
      for (int i = 1; i < 16; i++) send_byte(8'h00);
      send_byte(8'hD0);
      check("restart_run", {7'd0, cpu_run}, 8'h01);
      check("restart_err", {7'd0, load_err}, 8'h00);

      // Gapped transfers: 16 x 0xFF, checksum 0xF0
      pulse_start();
      for (int i = 0; i < 16; i++) begin
         int gap;
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) begin
            wr_data = 8'($urandom);
            tick();
         end
         send_byte(8'hFF);
      end
      tick(); tick();
      check("gap_check_rdy", {7'd0, wr_ready}, 8'h01);
      check("gap_check_run", {7'd0, cpu_run},  8'h00);
      send_byte(8'hF0);
      check("gap_run", {7'd0, cpu_run}, 8'h01);
      for (int a = 0; a < 16; a++) read_mem(4'(a), 8'hFF, "gap_mem");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Instruction-memory loader and store for the 4-bit CPU. Holds the 16×8 program memory that the CPU reads through `pc`/`inst`, and is the writer side of that interface. It accepts a 16-byte program plus an 8-bit checksum over a valid/ready byte stream. It gates CPU execution through `cpu_run` so the CPU only runs a program that has been fully loaded and verified.

## Interface
Parameters: none. Depth is fixed at 16 words and width at 8 bits, matching the 4-bit `pc` and 8-bit `inst`.

Ports:
- clk_cpu  input  1  CPU clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- pc  input  4  CPU fetch address.
- inst  output  8  program word at `pc`; a combinational read of the memory.
- load_start  input  1  one-cycle pulse that begins a new program load.
- wr_data  input  8  program or checksum byte.
- wr_valid  input  1  `wr_data` is valid.
- wr_ready  output  1  loader accepts a byte this cycle.
- cpu_run  output  1  high when the loaded program is verified. The integrator drives the CPU reset as `reset & cpu_run`.
- load_err  output  1  the last load failed its checksum.

## Operation
- Storage: mem[0..15] × 8 bits, plus a 4-bit `wr_cnt` and an 8-bit `sum`.
- `inst = mem[pc]` at all times, in every state.
- Transfer: a byte is accepted on a clock edge where `wr_valid && wr_ready`.
- State machine (encoding is free):
  - IDLE: `wr_ready` = 0, `cpu_run` = 0. `load_start` → LOAD.
  - LOAD: `wr_ready` = 1.
    - Each transfer writes `mem[wr_cnt] = wr_data`, sets `sum = sum + wr_data` (mod 256), and increments `wr_cnt`.
    - The transfer with `wr_cnt` = 15 moves to CHECK; `wr_cnt` wraps to 0.
  - CHECK: `wr_ready` = 1. One transfer compares `wr_data` against `sum`:
    - equal → RUN;
    - otherwise → ERR and `load_err` ← 1.
  - RUN: `wr_ready` = 0, `cpu_run` = 1. `load_start` → LOAD.
  - ERR: `wr_ready` = 0, `cpu_run` = 0, `load_err` = 1. `load_start` → LOAD.
- Entering LOAD from any state: `wr_cnt` ← 0, `sum` ← 0, `load_err` ← 0. Memory is not cleared; it is overwritten as bytes arrive.
- `load_start` while in LOAD or CHECK restarts the load.
  - A byte presented in the same cycle as `load_start` is dropped: no write, no sum update, and it is not counted.
- `wr_valid` in IDLE, RUN or ERR is ignored. Nothing is written.
- Reset (asynchronous, active-low, any time including mid-load):
  - state = IDLE, all mem words = 0x00, `wr_cnt` = 0, `sum` = 0.
  - `load_err` = 0, `cpu_run` = 0, `wr_ready` = 0, so `inst` = 0x00.
- `wr_valid` may be held low for any number of cycles between bytes; partial progress is kept.

## Timing
- `wr_ready`, `cpu_run` and `load_err` are registered state decodes. None depends combinationally on `wr_valid` or `wr_data`.
- A write at edge N is visible on `inst` (when `pc` selects it) after edge N.
- Throughput: 1 byte per cycle, so a back-to-back load takes 17 transfer cycles.
  - `cpu_run` rises the cycle after the accepted checksum edge.
- `load_start` in RUN: `cpu_run` falls on the next edge, holding the CPU in reset before any byte is written.
- Reset deasserts asynchronously for outputs. The first state change can occur on the first clock edge after release.

## Test plan
- Reset mid-LOAD after 5 bytes:
  - all outputs at reset values;
  - `inst` = 0x00 for every `pc`;
  - a new `load_start` is needed before `wr_ready` = 1.
- Back-to-back load:
  - stimulus: bytes 0x00..0x0F, then checksum 0x78;
  - response: `cpu_run` = 1 one cycle after the checksum edge, `load_err` = 0, and `pc` = 7 reads `inst` = 0x07.
- Bad checksum:
  - stimulus: same 16 bytes, then checksum 0x77;
  - response: `load_err` = 1, `cpu_run` = 0, `wr_ready` = 0;
  - a following `load_start` clears `load_err` the next cycle.
- Gapped transfers:
  - stimulus: all 16 bytes = 0xFF with `wr_valid` toggled randomly, then checksum 0xF0;
  - response: RUN reached and every address reads 0xFF.
- Restart:
  - stimulus: `load_start` asserted together with a valid byte during LOAD at `wr_cnt` = 9;
  - response: that byte is not written and counting restarts at address 0.
- Reload from RUN:
  - stimulus: `load_start` in RUN;
  - response: `cpu_run` = 0 the next cycle and `wr_ready` = 1;
  - the previous program stays readable until it is overwritten.
